// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller: states,
// instruction classes, opcode/funct fields and datapath select codes.
package multicycle_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALUI,
      CLS_LUI,
      CLS_LOAD,
      CLS_STORE,
      CLS_BNE,
      CLS_JAL,
      CLS_JALR,
      CLS_NONE
   } instr_class_t;

   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADDI = 3'b000;
   localparam logic [2:0] F3_XORI = 3'b100;
   localparam logic [2:0] F3_ANDI = 3'b111;
   localparam logic [2:0] F3_SLLI = 3'b001;
   localparam logic [2:0] F3_SRXI = 3'b101;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_JALR = 3'b000;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_SRA  = 7'b0100000;

   localparam logic [2:0] IMM_I     = 3'b000;
   localparam logic [2:0] IMM_SHAMT = 3'b001;
   localparam logic [2:0] IMM_J     = 3'b010;
   localparam logic [2:0] IMM_B     = 3'b011;
   localparam logic [2:0] IMM_S     = 3'b100;
   localparam logic [2:0] IMM_U     = 3'b101;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_XOR   = 4'b0001;
   localparam logic [3:0] ALU_AND   = 4'b0010;
   localparam logic [3:0] ALU_SLL   = 4'b0011;
   localparam logic [3:0] ALU_SRL   = 4'b0100;
   localparam logic [3:0] ALU_SRA   = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
   localparam logic [1:0] PCSRC_REL   = 2'b01;
   localparam logic [1:0] PCSRC_JALR  = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational instruction decoder: classifies the latched IR and produces
// the per-instruction datapath selects. Anything outside the supported subset
// is flagged illegal with all selects forced to their neutral values.
module multicycle_ctrl_decoder
   import multicycle_ctrl_pkg::*;
(
   input  logic [31:0]  instr,
   output instr_class_t cls,
   output logic [2:0]   imm_sel,
   output logic [3:0]   alu_op,
   output logic         alu_src_b,
   output logic         mem_byte,
   output logic         illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_fields;

   assign opcode        = instr[6:0];
   assign funct3        = instr[14:12];
   assign funct7        = instr[31:25];
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // Decode opcode/funct fields into class and selects; illegal encodings fall back to neutral values
   always_comb begin
      cls       = CLS_NONE;
      imm_sel   = IMM_I;
      alu_op    = ALU_ADD;
      alu_src_b = 1'b0;
      mem_byte  = 1'b0;
      illegal   = 1'b1;
      case (opcode)
         OP_ALUI: begin
            cls       = CLS_ALUI;
            alu_src_b = 1'b1;
            illegal   = 1'b0;
            case (funct3)
               F3_ADDI: alu_op = ALU_ADD;
               F3_XORI: alu_op = ALU_XOR;
               F3_ANDI: alu_op = ALU_AND;
               F3_SLLI: begin
                  imm_sel = IMM_SHAMT;
                  alu_op  = ALU_SLL;
                  illegal = (funct7 != F7_ZERO);
               end
               F3_SRXI: begin
                  imm_sel = IMM_SHAMT;
                  alu_op  = (funct7 == F7_SRA) ? ALU_SRA : ALU_SRL;
                  illegal = (funct7 != F7_ZERO) && (funct7 != F7_SRA);
               end
               default: illegal = 1'b1;
            endcase
         end
         OP_LOAD: begin
            if (funct3 == F3_LW || funct3 == F3_LBU) begin
               cls       = CLS_LOAD;
               alu_src_b = 1'b1;
               mem_byte  = (funct3 == F3_LBU);
               illegal   = 1'b0;
            end
         end
         OP_STORE: begin
            if (funct3 == F3_SW) begin
               cls       = CLS_STORE;
               imm_sel   = IMM_S;
               alu_src_b = 1'b1;
               illegal   = 1'b0;
            end
         end
         OP_BRANCH: begin
            if (funct3 == F3_BNE) begin
               cls     = CLS_BNE;
               imm_sel = IMM_B;
               alu_op  = ALU_SUB;
               illegal = 1'b0;
            end
         end
         OP_JAL: begin
            cls     = CLS_JAL;
            imm_sel = IMM_J;
            illegal = 1'b0;
         end
         OP_JALR: begin
            if (funct3 == F3_JALR) begin
               cls       = CLS_JALR;
               alu_src_b = 1'b1;
               illegal   = 1'b0;
            end
         end
         OP_LUI: begin
            cls       = CLS_LUI;
            imm_sel   = IMM_U;
            alu_op    = ALU_PASSB;
            alu_src_b = 1'b1;
            illegal   = 1'b0;
         end
         default: illegal = 1'b1;
      endcase
      if (illegal) begin
         cls       = CLS_NONE;
         imm_sel   = IMM_I;
         alu_op    = ALU_ADD;
         alu_src_b = 1'b0;
         mem_byte  = 1'b0;
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 subset core. One instruction in flight:
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with a sticky TRAP state
// for illegal instructions and memory timeouts, left only through rst.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 255,
   parameter int WAIT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        mem_ready,
   input  logic        zero,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_byte,
   output logic [2:0]  imm_sel,
   output logic        alu_src_b,
   output logic [3:0]  alu_op,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        illegal
);

   state_t            state;
   state_t            state_next;
   logic [WAIT_W-1:0] wait_cnt;
   logic              waiting;
   logic              timeout;

   instr_class_t      dec_cls;
   logic [2:0]        dec_imm_sel;
   logic [3:0]        dec_alu_op;
   logic              dec_alu_src_b;
   logic              dec_mem_byte;
   logic              dec_illegal;

   multicycle_ctrl_decoder u_decoder (
      .instr     (instr),
      .cls       (dec_cls),
      .imm_sel   (dec_imm_sel),
      .alu_op    (dec_alu_op),
      .alu_src_b (dec_alu_src_b),
      .mem_byte  (dec_mem_byte),
      .illegal   (dec_illegal)
   );

   // The cycle that would be the WAIT_MAX-th consecutive stall is the one that sends us to TRAP
   assign waiting = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready;
   assign timeout = waiting && (WAIT_MAX != 0) && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

   // State register and stall counter; the counter restarts whenever the state changes
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         if ((state_next != state) || !waiting) begin
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
         end
      end
   end

   // Next-state sequencing per instruction class
   always_comb begin
      state_next = state;
      case (state)
         ST_FETCH: begin
            if (mem_ready)    state_next = ST_DECODE;
            else if (timeout) state_next = ST_TRAP;
         end
         ST_DECODE: state_next = dec_illegal ? ST_TRAP : ST_EXEC;
         ST_EXEC: begin
            case (dec_cls)
               CLS_BNE:             state_next = ST_FETCH;
               CLS_LOAD, CLS_STORE: state_next = ST_MEM;
               default:             state_next = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (mem_ready)    state_next = (dec_cls == CLS_STORE) ? ST_FETCH : ST_WB;
            else if (timeout) state_next = ST_TRAP;
         end
         ST_WB:   state_next = ST_FETCH;
         ST_TRAP: state_next = ST_TRAP;
         default: state_next = ST_FETCH;
      endcase
   end

   // Per-state output decode; everything is held low while rst is asserted
   always_comb begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PCSRC_PLUS4;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      imm_sel   = IMM_I;
      alu_src_b = 1'b0;
      alu_op    = ALU_ADD;
      reg_write = 1'b0;
      wb_sel    = WB_ALU;
      illegal   = 1'b0;
      if (!rst) begin
         if ((state == ST_DECODE) || (state == ST_EXEC) || (state == ST_MEM) || (state == ST_WB)) begin
            imm_sel   = dec_imm_sel;
            alu_src_b = dec_alu_src_b;
            alu_op    = dec_alu_op;
         end
         case (state)
            ST_FETCH: begin
               mem_req  = 1'b1;
               ir_write = mem_ready;
               pc_write = mem_ready;
            end
            ST_EXEC: begin
               case (dec_cls)
                  CLS_BNE: begin
                     pc_write = ~zero;
                     pc_src   = PCSRC_REL;
                  end
                  CLS_JAL: begin
                     pc_write = 1'b1;
                     pc_src   = PCSRC_REL;
                  end
                  CLS_JALR: begin
                     pc_write = 1'b1;
                     pc_src   = PCSRC_JALR;
                  end
                  default: pc_write = 1'b0;
               endcase
            end
            ST_MEM: begin
               mem_req  = 1'b1;
               mem_we   = (dec_cls == CLS_STORE);
               mem_byte = dec_mem_byte;
            end
            ST_WB: begin
               reg_write = 1'b1;
               case (dec_cls)
                  CLS_LOAD:          wb_sel = WB_MEM;
                  CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
                  default:           wb_sel = WB_ALU;
               endcase
            end
            ST_TRAP: illegal = 1'b1;
            default: illegal = 1'b0;
         endcase
      end
   end

endmodule
